// File: rtl/adsr_env_if.sv
// Envelope port bundle: the note gate going in, amplitude and status coming out.
// There is no valid/ready handshake. gate is a level that the envelope
// samples on every clock. The outputs are continuously valid status.
interface adsr_env_if;
  logic       gate;
  logic [9:0] amp_out;
  logic [2:0] stage;
  logic       busy;
  logic       eoc;

  // Gate source / voice side
  modport master (output gate, input amp_out, stage, busy, eoc);
  // Envelope controller side
  modport slave  (input gate, output amp_out, stage, busy, eoc);
endinterface

// File: rtl/adsr_env.sv
// Tick-driven ADSR envelope: turns a raw gate into a 10-bit amplitude ramp.
// Gate edges change phase immediately. Amplitude steps happen only on
// prescaler ticks, and only when no gate edge occurs in the same cycle.
module adsr_env #(
  parameter int CLKSPEED     = 48_000_000,
  parameter int TICK_HZ      = 1000,
  parameter int ATTACK_STEP  = 8,
  parameter int DECAY_STEP   = 2,
  parameter int SUSTAIN      = 768,
  parameter int RELEASE_STEP = 4
) (
  input  logic         clk,
  input  logic         rst,
  adsr_env_if.slave    env
);

  localparam int DIV = CLKSPEED / TICK_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  // 11-bit limits so that SUSTAIN+DECAY_STEP (up to 2046) cannot overflow
  localparam logic [10:0] ATT_LIM = 11'(1023 - ATTACK_STEP);
  localparam logic [10:0] DEC_LIM = 11'(SUSTAIN + DECAY_STEP);
  localparam logic [10:0] REL_LIM = 11'(RELEASE_STEP);
  localparam logic [9:0]  A_STEP  = 10'(ATTACK_STEP);
  localparam logic [9:0]  D_STEP  = 10'(DECAY_STEP);
  localparam logic [9:0]  R_STEP  = 10'(RELEASE_STEP);
  localparam logic [9:0]  SUS_LVL = 10'(SUSTAIN);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [9:0]    amp, amp_n;
  logic          eoc_r, eoc_n;
  logic          gate_m, gate_s, gate_d;
  logic [CW-1:0] cnt;
  logic          tick, rise, fall;
  logic [10:0]   amp11;

  // Two-flop synchronizer plus a delay flop for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_m <= 1'b0;
      gate_s <= 1'b0;
      gate_d <= 1'b0;
    end else begin
      gate_m <= env.gate;
      gate_s <= gate_m;
      gate_d <= gate_s;
    end
  end

  assign rise = gate_s & ~gate_d;
  assign fall = ~gate_s & gate_d;

  // Free-running prescaler, 0..DIV-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
  end

  assign tick  = (cnt == CNT_MAX);
  assign amp11 = {1'b0, amp};

  // Phase, amplitude and end-of-note registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      amp   <= '0;
      eoc_r <= 1'b0;
    end else begin
      state <= state_n;
      amp   <= amp_n;
      eoc_r <= eoc_n;
    end
  end

  // Next state: gate edges take priority and suppress that cycle's step
  always_comb begin
    state_n = state;
    amp_n   = amp;
    eoc_n   = 1'b0;
    if (rise) begin
      state_n = S_ATTACK;
    end else if (fall) begin
      if (state == S_ATTACK || state == S_DECAY || state == S_SUSTAIN)
        state_n = S_RELEASE;
    end else if (tick) begin
      case (state)
        S_ATTACK: begin
          if (amp11 >= ATT_LIM) begin
            amp_n   = 10'd1023;
            state_n = S_DECAY;
          end else begin
            amp_n = amp + A_STEP;
          end
        end
        S_DECAY: begin
          if (amp11 <= DEC_LIM) begin
            amp_n   = SUS_LVL;
            state_n = S_SUSTAIN;
          end else begin
            amp_n = amp - D_STEP;
          end
        end
        S_RELEASE: begin
          if (amp11 <= REL_LIM) begin
            amp_n   = '0;
            state_n = S_IDLE;
            eoc_n   = 1'b1;
          end else begin
            amp_n = amp - R_STEP;
          end
        end
        S_IDLE:    amp_n = '0;
        default:   amp_n = amp;
      endcase
    end
  end

  assign env.amp_out = amp;
  assign env.stage   = state;
  assign env.busy    = (state != S_IDLE);
  assign env.eoc     = eoc_r;

endmodule

// File: tb/tb_adsr_env.sv
// Directed bench for adsr_env with DIV=10: a table of per-tick expectations
// plus hand-written sequences for reset, gate latency, retrigger and the
// edge/tick collision.
module tb_adsr_env;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   eoc_cnt;
  int   tb_cnt;

  adsr_env_if env ();

  adsr_env #(
    .CLKSPEED    (1000),
    .TICK_HZ     (100),
    .ATTACK_STEP (256),
    .DECAY_STEP  (64),
    .SUSTAIN     (512),
    .RELEASE_STEP(128)
  ) dut (
    .clk(clk),
    .rst(rst),
    .env(env)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference prescaler: the tick edge is the posedge where tb_cnt == 9
  always @(posedge clk or posedge rst) begin
    if (rst) tb_cnt <= 0;
    else     tb_cnt <= (tb_cnt == 9) ? 0 : tb_cnt + 1;
  end

  // Count end-of-note pulses
  always @(negedge clk) begin
    if (env.eoc) eoc_cnt <= eoc_cnt + 1;
  end

  typedef struct {
    logic       gate;
    logic [2:0] stage;
    logic [9:0] amp;
    logic       eoc;
  } row_t;

  row_t rows[$];

  function automatic void add(input logic g, input logic [2:0] st,
                              input logic [9:0] a, input logic e);
    row_t r;
    r.gate = g; r.stage = st; r.amp = a; r.eoc = e;
    rows.push_back(r);
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance past the next tick edge and stop on the following negedge
  task automatic next_tick();
    int n = 0;
    while (tb_cnt != 9 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("tick_timeout", n, 0);
    @(negedge clk);
  endtask

  task automatic check_state(input string name, input logic [2:0] st, input logic [9:0] a);
    check({name, "_stage"}, int'(env.stage), int'(st));
    check({name, "_amp"},   int'(env.amp_out), int'(a));
    check({name, "_busy"},  int'(env.busy), int'(st != 3'd0));
  endtask

  // Apply table rows lo..hi: set gate, advance one tick, compare
  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      env.gate = rows[i].gate;
      next_tick();
      check_state($sformatf("row%0d", i), rows[i].stage, rows[i].amp);
      check($sformatf("row%0d_eoc", i), int'(env.eoc), int'(rows[i].eoc));
      if (rows[i].eoc) begin
        @(negedge clk);
        check($sformatf("row%0d_eoc_clear", i), int'(env.eoc), 0);
        check($sformatf("row%0d_idle_hold", i), int'(env.stage), 0);
      end
    end
  endtask

  initial begin
    int eoc_snap;
    checks = 0; errors = 0; eoc_cnt = 0;
    rst = 1'b1;
    env.gate = 1'b0;

    // Full note and release: rows 0..35
    add(1, 1, 256, 0); add(1, 1, 512, 0); add(1, 1, 768, 0); add(1, 2, 1023, 0);
    add(1, 2, 959, 0); add(1, 2, 895, 0); add(1, 2, 831, 0); add(1, 2, 767, 0);
    add(1, 2, 703, 0); add(1, 2, 639, 0); add(1, 2, 575, 0); add(1, 3, 512, 0);
    for (int i = 0; i < 20; i++) add(1, 3, 512, 0);
    add(0, 4, 384, 0); add(0, 4, 256, 0); add(0, 4, 128, 0); add(0, 0, 0, 1);
    // Early release: attack rows 36..37, release rows 38..41
    add(1, 1, 256, 0); add(1, 1, 512, 0);
    add(0, 4, 384, 0); add(0, 4, 256, 0); add(0, 4, 128, 0); add(0, 0, 0, 1);
    // Retrigger: rows 42..45 up and down, rows 46..47 after retrigger
    add(1, 1, 256, 0); add(1, 1, 512, 0); add(0, 4, 384, 0); add(0, 4, 256, 0);
    add(1, 1, 512, 0); add(1, 1, 768, 0);

    repeat (3) @(negedge clk);
    check_state("reset", 3'd0, 10'd0);
    check("reset_eoc", int'(env.eoc), 0);

    // Reach ATTACK at amp 512, then reset asynchronously mid-note
    rst = 1'b0;
    env.gate = 1'b1;
    next_tick();
    next_tick();
    check_state("pre_reset", 3'd1, 10'd512);
    rst = 1'b1;
    #1;
    check_state("async_reset", 3'd0, 10'd0);
    check("async_reset_eoc", int'(env.eoc), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_e1_stage", int'(env.stage), 0);
    @(negedge clk);
    check("rel_e2_stage", int'(env.stage), 0);
    @(negedge clk);
    check_state("rel_e3", 3'd1, 10'd0);

    // Full note, sustain, release
    run_rows(0, 35);
    check("eoc_count_note", eoc_cnt, 1);

    // Early release from ATTACK at 512
    run_rows(36, 37);
    env.gate = 1'b0;
    repeat (3) @(negedge clk);
    check_state("early_rel_entry", 3'd4, 10'd512);
    run_rows(38, 41);
    check("eoc_count_early", eoc_cnt, 2);

    // Retrigger during RELEASE at 256
    run_rows(42, 45);
    eoc_snap = eoc_cnt;
    env.gate = 1'b1;
    repeat (3) @(negedge clk);
    check_state("retrig_entry", 3'd1, 10'd256);
    run_rows(46, 47);
    check("retrig_no_eoc", eoc_cnt, eoc_snap);

    // Edge/tick collision: rise lands in the tick cycle during RELEASE
    env.gate = 1'b0;
    repeat (3) @(negedge clk);
    check_state("coll_rel_entry", 3'd4, 10'd768);
    next_tick();
    check_state("coll_rel_step", 3'd4, 10'd640);
    begin
      int n = 0;
      while (tb_cnt != 7 && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (n >= 20) check("align_timeout", n, 0);
    end
    env.gate = 1'b1;
    repeat (3) @(negedge clk);
    check_state("coll_edge", 3'd1, 10'd640);
    repeat (9) @(negedge clk);
    check("coll_hold_9", int'(env.amp_out), 640);
    @(negedge clk);
    check_state("coll_first_step", 3'd1, 10'd896);
    check("eoc_total", eoc_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
